// File: rtl/event_sched_pkg.sv
// Shared types and default parameters for the event transmit scheduler.
// EVT_TIMESTAMP_EN adds a timestamp field to evt_t.
package event_sched_pkg;

  localparam int unsigned ADD_W_DEF        = 1;
  localparam int unsigned DEPTH_DEF        = 4;
  localparam int unsigned STALL_MARGIN_DEF = 1;
  localparam int unsigned TS_W_DEF         = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    THROTTLE = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [ADD_W_DEF-1:0] x;
    logic [ADD_W_DEF-1:0] y;
    logic                 last;
`ifdef EVT_TIMESTAMP_EN
    logic [TS_W_DEF-1:0]  ts;
`endif
  } evt_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as zero while empty.
module event_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is accepted when a read frees the slot in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/event_tx_scheduler.sv
// Arbiter sequencer: drives enable, buffers granted addresses as events, drains on group release.
// Optional EVT_TIMESTAMP_EN stamps each event with a free-running counter (evt_ts_o).
module event_tx_scheduler
  import event_sched_pkg::*;
#(
  parameter int unsigned ADD_W        = ADD_W_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned STALL_MARGIN = STALL_MARGIN_DEF,
  parameter int unsigned TS_W         = TS_W_DEF,
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             grp_release_clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             gnt_valid_i,
  input  logic [ADD_W-1:0] x_add_i,
  input  logic [ADD_W-1:0] y_add_i,
  input  logic             grp_release_i,
  output logic             enable_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ADD_W-1:0] evt_x_o,
  output logic [ADD_W-1:0] evt_y_o,
  output logic             evt_last_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  evt_ts_o
`endif
);

`ifdef EVT_TIMESTAMP_EN
  localparam int unsigned TS_BITS = TS_W;
`else
  // TS_W only sizes the optional timestamp field.
  localparam int unsigned TS_BITS = TS_W - TS_W;
`endif
  localparam int unsigned FIFO_W = 2 * ADD_W + 1 + TS_BITS;

  sched_state_t      state, state_next;
  logic [FIFO_W-1:0] wr_word;
  logic [FIFO_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              throttle_c;

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign wr_word  = {x_add_i, y_add_i, grp_release_i, ts_cnt};
  assign evt_ts_o = head[TS_BITS-1:0];
`else
  assign wr_word  = {x_add_i, y_add_i, grp_release_i};
`endif

  assign evt_valid_o = !fifo_empty;
  assign pop         = evt_valid_o && evt_ready_i;
  assign evt_x_o     = head[FIFO_W-1 -: ADD_W];
  assign evt_y_o     = head[FIFO_W-1-ADD_W -: ADD_W];
  assign evt_last_o  = head[TS_BITS];
  assign throttle_c  = (CNT_W'(DEPTH) - count_o) <= CNT_W'(STALL_MARGIN);

  event_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (grp_release_clk),
    .rst     (reset_i),
    .wr_en   (gnt_valid_i),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge grp_release_clk or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      enable_o   <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state    <= state_next;
      enable_o <= (state == RUN);
      if (gnt_valid_i && fifo_full && !pop) overflow_o <= 1'b1;
    end
  end

  // Next-state decode; release and stop take precedence over leaving throttle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_i) state_next = RUN;
      RUN: begin
        if (grp_release_i)   state_next = DRAIN;
        else if (throttle_c) state_next = THROTTLE;
        else if (!start_i)   state_next = DRAIN;
      end
      THROTTLE: begin
        if (grp_release_i || !start_i) state_next = DRAIN;
        else if (!throttle_c)          state_next = RUN;
      end
      DRAIN:    if (count_o == '0) state_next = start_i ? RUN : IDLE;
      default:  state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_event_tx_scheduler.sv
// Directed self-checking bench for event_tx_scheduler (DEPTH=4, STALL_MARGIN=1, ADD_W=1).
module tb_event_tx_scheduler;

  localparam int unsigned ADD_W = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             start_i;
  logic             gnt_valid_i;
  logic [ADD_W-1:0] x_add_i;
  logic [ADD_W-1:0] y_add_i;
  logic             grp_release_i;
  logic             enable_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [ADD_W-1:0] evt_x_o;
  logic [ADD_W-1:0] evt_y_o;
  logic             evt_last_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0]  evt_ts_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  event_tx_scheduler #(
    .ADD_W        (ADD_W),
    .DEPTH        (DEPTH),
    .STALL_MARGIN (1),
    .TS_W         (TS_W)
  ) dut (
    .grp_release_clk (clk),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .gnt_valid_i     (gnt_valid_i),
    .x_add_i         (x_add_i),
    .y_add_i         (y_add_i),
    .grp_release_i   (grp_release_i),
    .enable_o        (enable_o),
    .evt_valid_o     (evt_valid_o),
    .evt_ready_i     (evt_ready_i),
    .evt_x_o         (evt_x_o),
    .evt_y_o         (evt_y_o),
    .evt_last_o      (evt_last_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
`ifdef EVT_TIMESTAMP_EN
    ,
    .evt_ts_o        (evt_ts_o)
`endif
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic x, input logic y, input logic rel);
    gnt_valid_i   = 1'b1;
    x_add_i       = x;
    y_add_i       = y;
    grp_release_i = rel;
    tick();
    gnt_valid_i   = 1'b0;
    grp_release_i = 1'b0;
  endtask

  task automatic check_head(input string tag, input int unsigned x, input int unsigned y,
                            input int unsigned last, input int unsigned cnt);
    check_eq({tag, "_valid"}, 32'(evt_valid_o), 1);
    check_eq({tag, "_x"},     32'(evt_x_o), x);
    check_eq({tag, "_y"},     32'(evt_y_o), y);
    check_eq({tag, "_last"},  32'(evt_last_o), last);
    check_eq({tag, "_count"}, 32'(count_o), cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_enable"},   32'(enable_o), 0);
    check_eq({tag, "_valid"},    32'(evt_valid_o), 0);
    check_eq({tag, "_x"},        32'(evt_x_o), 0);
    check_eq({tag, "_y"},        32'(evt_y_o), 0);
    check_eq({tag, "_last"},     32'(evt_last_o), 0);
    check_eq({tag, "_count"},    32'(count_o), 0);
    check_eq({tag, "_overflow"}, 32'(overflow_o), 0);
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; gnt_valid_i = 1'b0;
    x_add_i = '0; y_add_i = '0; grp_release_i = 1'b0; evt_ready_i = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_i = 1'b0;

    // Single event closing a group; enable dips during drain
    start_i = 1'b1; evt_ready_i = 1'b1;
    tick();
    check_eq("t1_enable_idle", 32'(enable_o), 0);
    tick();
    check_eq("t1_enable_run", 32'(enable_o), 1);
    grant(1'b1, 1'b0, 1'b1);
    check_head("t1_evt", 1, 0, 1, 1);
    tick();
    check_eq("t1_popped", 32'(evt_valid_o), 0);
    check_eq("t1_enable_drain", 32'(enable_o), 0);
    tick();
    tick();
    check_eq("t1_enable_back", 32'(enable_o), 1);

    // Throttle at three entries, recover after one pop
    evt_ready_i = 1'b0;
    grant(1'b0, 1'b1, 1'b0);
    grant(1'b1, 1'b1, 1'b0);
    grant(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("t2_enable_throttled", 32'(enable_o), 0);
    check_head("t2_head", 0, 1, 0, 3);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check_eq("t2_count_after_pop", 32'(count_o), 2);
    tick();
    tick();
    check_eq("t2_enable_resumed", 32'(enable_o), 1);
    check_head("t2_head2", 1, 1, 0, 2);

    // Fill to four entries
    grant(1'b0, 1'b0, 1'b0);
    grant(1'b0, 1'b1, 1'b0);
    check_head("fill", 1, 1, 0, 4);

    // Full with simultaneous push and pop
    evt_ready_i = 1'b1;
    grant(1'b1, 1'b0, 1'b1);
    evt_ready_i = 1'b0;
    check_eq("t4_count", 32'(count_o), 4);
    check_eq("t4_no_overflow", 32'(overflow_o), 0);
    check_head("t4_head", 1, 0, 0, 4);

    // Full with push only: dropped, sticky overflow
    grant(1'b0, 1'b0, 1'b0);
    check_eq("t3_overflow", 32'(overflow_o), 1);
    check_head("t3_head", 1, 0, 0, 4);

    evt_ready_i = 1'b1;
    tick();
    check_head("pop1", 0, 0, 0, 3);
    tick();
    check_head("pop2", 0, 1, 0, 2);
    tick();
    check_head("pop3_new_entry", 1, 0, 1, 1);
    tick();
    check_eq("pop4_valid", 32'(evt_valid_o), 0);
    check_eq("pop4_count", 32'(count_o), 0);
    check_eq("t3_overflow_sticky", 32'(overflow_o), 1);
    tick();
    grant(1'b1, 1'b1, 1'b0);
    check_head("later", 1, 1, 0, 1);
    tick();
    check_eq("later_count", 32'(count_o), 0);
    check_eq("later_overflow", 32'(overflow_o), 1);

    // Asynchronous reset with four events buffered
    evt_ready_i = 1'b0;
    grant(1'b0, 1'b1, 1'b0);
    grant(1'b1, 1'b0, 1'b0);
    grant(1'b1, 1'b1, 1'b0);
    grant(1'b0, 1'b0, 1'b0);
    check_eq("t5_count_full", 32'(count_o), 4);
    #2;
    reset_i = 1'b1;
    #1;
    check_all_zero("t5_async");
    #3;
    reset_i = 1'b0;
    evt_ready_i = 1'b1;
    tick();
    check_eq("t5_no_stale_valid", 32'(evt_valid_o), 0);
    check_eq("t5_no_stale_count", 32'(count_o), 0);
    tick();
    check_eq("t5_no_stale_valid2", 32'(evt_valid_o), 0);

`ifdef EVT_TIMESTAMP_EN
    // Counter was 0 at the first edge after reset release; two edges have passed
    evt_ready_i = 1'b0;
    tick(); tick(); tick();
    grant(1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    grant(1'b0, 1'b1, 1'b0);
    check_eq("t6_ts_first", 32'(evt_ts_o), 5);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check_eq("t6_ts_second", 32'(evt_ts_o), 9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
